// File: rtl/fall_tick_scheduler.sv
// Note-fall tick scheduler: turns the divider period into 1-cycle fall_tick enables under an idle/run/pause/over FSM.
// Latency: first fall_tick is registered period_lat cycles after the accepted start edge, then every period_lat run cycles.
// Backpressure: none; pulse inputs are priority-resolved game_over > pause_tgl > start. Optional macro AUTO_RAMP_EN.
module fall_tick_scheduler #(
  parameter int MIN_PERIOD = 2,
  parameter int RAMP_TICKS = 64,
  parameter int MAX_DIFF   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause_tgl,
  input  logic        game_over,
  input  logic [3:0]  diff_init,
  input  logic [31:0] refresh_max,
  output logic [3:0]  difficulty,
  output logic        fall_tick,
  output logic [15:0] tick_count,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam logic [3:0]  MAX_D   = 4'(MAX_DIFF);

  // Reject parameter values the counters cannot represent.
  if (RAMP_TICKS < 1 || RAMP_TICKS > 65535) begin : g_bad_ramp
    $error("RAMP_TICKS must be in 1..65535");
  end
  if (MIN_PERIOD < 2) begin : g_bad_min
    $error("MIN_PERIOD must be at least 2");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_lat_q, period_lat_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic [3:0]  difficulty_q, difficulty_d;
  logic        fall_tick_q, fall_tick_d;
  logic [31:0] period_clamped;
  logic [3:0]  diff_start;

`ifdef AUTO_RAMP_EN
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_TICKS - 1);
  logic [15:0] ramp_cnt_q, ramp_cnt_d;
`endif

  // Floor the divider period so the period_lat-1 compare never wraps.
  assign period_clamped = (refresh_max < MIN_P) ? MIN_P : refresh_max;
  assign diff_start     = (diff_init > MAX_D) ? MAX_D : diff_init;

  // Next-state logic: FSM, period counter, tick counter and difficulty.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_lat_d = period_lat_q;
    tick_count_d = tick_count_q;
    difficulty_d = difficulty_q;
    fall_tick_d  = 1'b0;
`ifdef AUTO_RAMP_EN
    ramp_cnt_d   = ramp_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        // game_over and pause_tgl carry no meaning here, so they cannot block a start.
        if (start) begin
          state_d      = S_RUN;
          cnt_d        = 32'd0;
          tick_count_d = 16'd0;
          difficulty_d = diff_start;
          period_lat_d = period_clamped;
`ifdef AUTO_RAMP_EN
          ramp_cnt_d   = 16'd0;
`endif
        end
      end
      S_RUN: begin
        if (game_over) begin
          state_d = S_OVER;
        end else if (pause_tgl) begin
          state_d = S_PAUSE;
        end else if (cnt_q == period_lat_q - 32'd1) begin
          // Tick boundary: the only point where a new divider period is accepted.
          fall_tick_d  = 1'b1;
          cnt_d        = 32'd0;
          period_lat_d = period_clamped;
          if (tick_count_q != 16'hFFFF) begin
            tick_count_d = tick_count_q + 16'd1;
          end
`ifdef AUTO_RAMP_EN
          if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = 16'd0;
            if (difficulty_q < MAX_D) begin
              difficulty_d = difficulty_q + 4'd1;
            end
          end else begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PAUSE: begin
        if (game_over) begin
          state_d = S_OVER;
        end else if (pause_tgl) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset so fall_tick drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      period_lat_q <= 32'd0;
      tick_count_q <= 16'd0;
      difficulty_q <= 4'd0;
      fall_tick_q  <= 1'b0;
`ifdef AUTO_RAMP_EN
      ramp_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_lat_q <= period_lat_d;
      tick_count_q <= tick_count_d;
      difficulty_q <= difficulty_d;
      fall_tick_q  <= fall_tick_d;
`ifdef AUTO_RAMP_EN
      ramp_cnt_q   <= ramp_cnt_d;
`endif
    end
  end

  assign state      = state_q;
  assign fall_tick  = fall_tick_q;
  assign tick_count = tick_count_q;
  assign difficulty = difficulty_q;

endmodule

// File: tb/tb_fall_tick_scheduler.sv
// Testbench for fall_tick_scheduler: directed scenarios plus a per-cycle reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Expected difficulty after ramping depends on whether AUTO_RAMP_EN is defined.
module tb_fall_tick_scheduler;

  localparam int MAXD = 15;
  localparam int RT   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pause_tgl, game_over;
  logic [3:0]  diff_init;
  logic [31:0] refresh_max;
  logic [3:0]  difficulty;
  logic        fall_tick;
  logic [15:0] tick_count;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  fall_tick_scheduler #(.MIN_PERIOD(2), .RAMP_TICKS(RT), .MAX_DIFF(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause_tgl(pause_tgl),
    .game_over(game_over), .diff_init(diff_init), .refresh_max(refresh_max),
    .difficulty(difficulty), .fall_tick(fall_tick), .tick_count(tick_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: game phases, run cycles elapsed since the last tick, and the period in force.
  int          m_state;    // 0 idle, 1 run, 2 pause, 3 over
  int unsigned m_elapsed;
  int unsigned m_period;
  int          m_ticks;
  int          m_diff;
  int          m_ramp;
  bit          m_tick;

  function automatic int unsigned clampp(input logic [31:0] v);
    return (v < 32'd2) ? 2 : int'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_elapsed <= 0; m_period <= 0; m_ticks <= 0;
      m_diff <= 0; m_ramp <= 0; m_tick <= 0;
    end else begin
      m_tick <= 0;
      if (m_state == 0 || m_state == 3) begin
        if (start) begin
          m_state <= 1; m_elapsed <= 0; m_ticks <= 0; m_ramp <= 0;
          m_diff <= (int'(diff_init) > MAXD) ? MAXD : int'(diff_init);
          m_period <= clampp(refresh_max);
        end
      end else if (m_state == 1) begin
        if (game_over) m_state <= 3;
        else if (pause_tgl) m_state <= 2;
        else if (m_elapsed + 1 == m_period) begin
          m_tick <= 1;
          m_elapsed <= 0;
          m_period <= clampp(refresh_max);
          m_ticks <= (m_ticks == 65535) ? 65535 : m_ticks + 1;
`ifdef AUTO_RAMP_EN
          if (m_ramp + 1 == RT) begin
            m_ramp <= 0;
            m_diff <= (m_diff + 1 > MAXD) ? MAXD : m_diff + 1;
          end else m_ramp <= m_ramp + 1;
`endif
        end else m_elapsed <= m_elapsed + 1;
      end else begin
        if (game_over) m_state <= 3;
        else if (pause_tgl) m_state <= 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_fall_tick", 32'(fall_tick), 32'(m_tick));
    chk("m_tick_count", 32'(tick_count), 32'(m_ticks));
    chk("m_difficulty", 32'(difficulty), 32'(m_diff));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_go();
    game_over = 1'b1; step(1); game_over = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_tgl = 1'b1; step(1); pause_tgl = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause_tgl = 1'b0; game_over = 1'b0;
    diff_init = 4'd3; refresh_max = 32'd10;
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_diff", 32'(difficulty), 32'd0);
    chk("rst_fall", 32'(fall_tick), 32'd0);
    chk("rst_tc", 32'(tick_count), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Basic run: period 10, ticks at E10, E20, E30.
    pulse_start();
    chk("s1_state", 32'(state), 32'd1);
    chk("s1_diff", 32'(difficulty), 32'd3);
    step(9);  chk("s1_e9_fall", 32'(fall_tick), 32'd0);
    step(1);  chk("s1_e10_fall", 32'(fall_tick), 32'd1); chk("s1_e10_tc", 32'(tick_count), 32'd1);
    step(1);  chk("s1_e11_fall", 32'(fall_tick), 32'd0);
    step(9);  chk("s1_e20_fall", 32'(fall_tick), 32'd1);
    step(10); chk("s1_e30_fall", 32'(fall_tick), 32'd1); chk("s1_e30_tc", 32'(tick_count), 32'd3);
    pulse_go();
    chk("s1_over", 32'(state), 32'd3);

    // Period clamp: refresh_max=1 runs at period 2.
    refresh_max = 32'd1;
    pulse_start();
    step(1); chk("s2_e1_fall", 32'(fall_tick), 32'd0);
    step(1); chk("s2_e2_fall", 32'(fall_tick), 32'd1);
    step(1); chk("s2_e3_fall", 32'(fall_tick), 32'd0);
    step(1); chk("s2_e4_fall", 32'(fall_tick), 32'd1);
    pulse_go();

    // Pause at cnt=4 for 7 cycles; tick lands 6 cycles after resume.
    refresh_max = 32'd10;
    pulse_start();
    step(4);
    pulse_pause();
    chk("s3_paused", 32'(state), 32'd2);
    for (int i = 0; i < 6; i++) begin
      step(1); chk("s3_pause_fall", 32'(fall_tick), 32'd0);
    end
    pulse_pause();
    chk("s3_resumed", 32'(state), 32'd1);
    step(5); chk("s3_r5_fall", 32'(fall_tick), 32'd0);
    step(1); chk("s3_r6_fall", 32'(fall_tick), 32'd1); chk("s3_r6_tc", 32'(tick_count), 32'd1);
    pulse_go();

    // Mid-period change 10 -> 20 applies only after the next tick.
    refresh_max = 32'd10;
    pulse_start();
    step(3); refresh_max = 32'd20;
    step(7);  chk("s4_e10_fall", 32'(fall_tick), 32'd1);
    step(19); chk("s4_e29_fall", 32'(fall_tick), 32'd0);
    step(1);  chk("s4_e30_fall", 32'(fall_tick), 32'd1);
    pulse_go();

    // game_over with start in RUN: over wins, counters freeze, later start clears.
    refresh_max = 32'd10;
    pulse_start();
    step(10); chk("s5_tc1", 32'(tick_count), 32'd1);
    game_over = 1'b1; start = 1'b1;
    step(1);
    game_over = 1'b0; start = 1'b0;
    chk("s5_state", 32'(state), 32'd3);
    chk("s5_fall", 32'(fall_tick), 32'd0);
    step(5); chk("s5_frozen_tc", 32'(tick_count), 32'd1);
    pulse_start();
    chk("s5_restart_state", 32'(state), 32'd1);
    chk("s5_restart_tc", 32'(tick_count), 32'd0);
    pulse_go();

    // Difficulty ramp with period 2 and diff_init=14.
    refresh_max = 32'd2; diff_init = 4'd14;
    pulse_start();
    step(8);
`ifdef AUTO_RAMP_EN
    chk("s6_diff_4ticks", 32'(difficulty), 32'd15);
`else
    chk("s6_diff_4ticks", 32'(difficulty), 32'd14);
`endif
    step(8);
`ifdef AUTO_RAMP_EN
    chk("s6_diff_8ticks", 32'(difficulty), 32'd15);
`else
    chk("s6_diff_8ticks", 32'(difficulty), 32'd14);
`endif
    chk("s6_tc", 32'(tick_count), 32'd8);
    pulse_go();

    // Asynchronous reset while fall_tick is high.
    refresh_max = 32'd10; diff_init = 4'd3;
    pulse_start();
    step(10); chk("s7_fall_before", 32'(fall_tick), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s7_fall_async", 32'(fall_tick), 32'd0);
    chk("s7_state_async", 32'(state), 32'd0);
    chk("s7_tc_async", 32'(tick_count), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("s7_idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
